// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: 2-entry IF/ID buffer (head + skid), load-use
// hazard detection against the load in EX, redirect flush and a stall counter.
module id_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  output logic              dec_valid,
  output logic [XLEN-1:0]   dec_instr,
  output logic [XLEN-1:0]   dec_pc,
  input  logic              dec_rs1_read,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic              dec_rs2_read,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic              dec_rd_write,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic              dec_mem_read,
  input  logic              id_ready,
  input  logic              ex_flush,
  output logic              id_issue,
  output logic              id_bubble,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [XLEN-1:0]   head_instr_q, head_instr_d;
  logic [XLEN-1:0]   head_pc_q,    head_pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q,    skid_pc_d;
  logic              ld_v_q,       ld_v_d;
  logic [REG_AW-1:0] ld_rd_q,      ld_rd_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic push;
  logic pop;
  logic rs1_hit;
  logic rs2_hit;

  // if_ready looks only at registered state so fetch never sees a path from id_ready.
  assign if_ready  = ~rst & (state_q != ST_TWO);
  assign dec_valid = (state_q != ST_EMPTY);
  assign dec_instr = head_instr_q;
  assign dec_pc    = head_pc_q;

  assign rs1_hit      = dec_rs1_read & (dec_rs1_addr == ld_rd_q);
  assign rs2_hit      = dec_rs2_read & (dec_rs2_addr == ld_rd_q);
  assign hazard_stall = dec_valid & ld_v_q & (ld_rd_q != '0) & (rs1_hit | rs2_hit);
  assign id_issue     = dec_valid & id_ready & ~hazard_stall & ~ex_flush;
  assign id_bubble    = id_ready & ~id_issue;
  assign stall_cnt    = cnt_q;

  assign push = if_valid & if_ready & ~ex_flush;
  assign pop  = id_issue;

  always_comb begin
    // NOTE: every next-state signal gets a default hold value first so no path infers a latch.
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (ex_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d      = ST_ONE;
            head_instr_d = if_instr;
            head_pc_d    = if_pc;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_instr_d = if_instr;
            head_pc_d    = if_pc;
          end else if (push) begin
            state_d      = ST_TWO;
            skid_instr_d = if_instr;
            skid_pc_d    = if_pc;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d      = ST_ONE;
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // The tracker mirrors what enters EX: a bubble replaces the load, so a hazard lasts one id_ready cycle.
  always_comb begin
    ld_v_d  = ld_v_q;
    ld_rd_d = ld_rd_q;
    if (ex_flush) begin
      ld_v_d = 1'b0;
    end else if (id_ready) begin
      ld_v_d  = id_issue & dec_mem_read & dec_rd_write;
      ld_rd_d = dec_rd_addr;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && id_ready && !ex_flush && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ld_v_q       <= 1'b0;
      ld_rd_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ld_v_q       <= ld_v_d;
      ld_rd_q      <= ld_rd_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Randomized bench for id_issue_ctrl: a queue-based reference model predicts
// outputs, and a scoreboard monitor checks every issued instruction in order.
module tb_id_issue_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct packed {
    logic       rs1r;
    logic [4:0] rs1;
    logic       rs2r;
    logic [4:0] rs2;
    logic       rdw;
    logic [4:0] rd;
    logic       mem;
  } dec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             if_ready;
  logic             dec_valid;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic             dec_rs1_read;
  logic [4:0]       dec_rs1_addr;
  logic             dec_rs2_read;
  logic [4:0]       dec_rs2_addr;
  logic             dec_rd_write;
  logic [4:0]       dec_rd_addr;
  logic             dec_mem_read;
  logic             id_ready;
  logic             ex_flush;
  logic             id_issue;
  logic             id_bubble;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  entry_t           buf_q[$];
  entry_t           exp_q[$];
  logic             ld_v_m;
  logic [4:0]       ld_rd_m;
  int unsigned      cnt_m;
  logic [31:0]      pc_ctr;

  always #5 clk = ~clk;

  id_issue_ctrl #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .dec_valid    (dec_valid),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_rs1_read (dec_rs1_read),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_read (dec_rs2_read),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rd_write (dec_rd_write),
    .dec_rd_addr  (dec_rd_addr),
    .dec_mem_read (dec_mem_read),
    .id_ready     (id_ready),
    .ex_flush     (ex_flush),
    .id_issue     (id_issue),
    .id_bubble    (id_bubble),
    .hazard_stall (hazard_stall),
    .stall_cnt    (stall_cnt)
  );

  // Minimal RV32 decoder for the instruction classes the bench generates.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d      = '0;
    d.rd   = ins[11:7];
    d.rs1  = ins[19:15];
    d.rs2  = ins[24:20];
    case (ins[6:0])
      7'h13: begin d.rs1r = 1'b1; d.rdw = 1'b1; end
      7'h33: begin d.rs1r = 1'b1; d.rs2r = 1'b1; d.rdw = 1'b1; end
      7'h03: begin d.rs1r = 1'b1; d.rdw = 1'b1; d.mem = 1'b1; end
      7'h23: begin d.rs1r = 1'b1; d.rs2r = 1'b1; end
      7'h37: begin d.rdw = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    dec_t d;
    d            = decode(dec_instr);
    dec_rs1_read = d.rs1r;
    dec_rs1_addr = d.rs1;
    dec_rs2_read = d.rs2r;
    dec_rs2_addr = d.rs2;
    dec_rd_write = d.rdw;
    dec_rd_addr  = d.rd;
    dec_mem_read = d.mem;
  end

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0: return {12'h005, b, 3'b000, a, 7'h13};
      1: return {7'h00, c, b, 3'b000, a, 7'h33};
      2: return {12'h000, b, 3'b010, a, 7'h03};
      3: return {7'h00, c, b, 3'b010, 5'h00, 7'h23};
      default: return {20'h12345, a, 7'h37};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue of at most two entries.
  task automatic model_step();
    dec_t        hd;
    logic        dv, haz, iss;
    int unsigned sz;
    if (rst) begin
      check("if_ready_in_reset", 64'(if_ready), 64'(0));
      buf_q.delete();
      ld_v_m  = 1'b0;
      ld_rd_m = '0;
      cnt_m   = 0;
      return;
    end
    sz  = buf_q.size();
    dv  = (sz > 0);
    hd  = dv ? decode(buf_q[0].instr) : '0;
    haz = dv && ld_v_m && (ld_rd_m != 0) &&
          ((hd.rs1r && hd.rs1 == ld_rd_m) || (hd.rs2r && hd.rs2 == ld_rd_m));
    iss = dv && id_ready && !haz && !ex_flush;

    check("if_ready",     64'(if_ready),     64'(sz < 2));
    check("dec_valid",    64'(dec_valid),    64'(dv));
    check("hazard_stall", 64'(hazard_stall), 64'(haz));
    check("id_issue",     64'(id_issue),     64'(iss));
    check("id_bubble",    64'(id_bubble),    64'(id_ready && !iss));
    check("stall_cnt",    64'(stall_cnt),    64'(cnt_m));
    if (dv) begin
      check("dec_instr", 64'(dec_instr), 64'(buf_q[0].instr));
      check("dec_pc",    64'(dec_pc),    64'(buf_q[0].pc));
    end

    if (iss) exp_q.push_back(buf_q[0]);

    if (haz && id_ready && !ex_flush && cnt_m < (2**CNT_W - 1)) cnt_m++;

    if (ex_flush) begin
      ld_v_m = 1'b0;
      buf_q.delete();
    end else begin
      if (id_ready) begin
        ld_v_m  = iss && hd.mem && hd.rdw;
        ld_rd_m = hd.rd;
      end
      if (iss) void'(buf_q.pop_front());
      if (if_valid && sz < 2) buf_q.push_back('{instr: if_instr, pc: if_pc});
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic r);
    @(negedge clk);
    rst      = r;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    id_ready = rdy;
    ex_flush = fl;
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every DUT issue must match the oldest predicted issue.
  always @(negedge clk) begin
    entry_t e;
    #2;
    if (rst === 1'b0 && id_issue === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_issue", 64'(dec_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", 64'(dec_instr), 64'(e.instr));
        check("sb_pc",    64'(dec_pc),    64'(e.pc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b0; ex_flush = 1'b0;
    ld_v_m = 1'b0; ld_rd_m = '0; cnt_m = 0; pc_ctr = 32'h1000;

    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
    check("reset_dec_valid", 64'(dec_valid), 64'(0));

    // Single addi: visible and issued the cycle after acceptance.
    cycle(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Back-to-back ALU stream.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, {12'h001, 5'd1, 3'b000, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Load-use stall, then the same pair targeting x0.
    cycle(1'b1, 32'h0001_2283, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0012_8333, 32'h304, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("stall_cnt_after_hazard", 64'(stall_cnt), 64'(1));
    cycle(1'b1, 32'h0001_2003, 32'h310, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0010_0333, 32'h314, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("stall_cnt_x0_no_hazard", 64'(stall_cnt), 64'(1));

    // EX stalled while fetch streams: skid fills, then drains in order.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, {20'h0ABCD, 5'(i + 1), 7'h37}, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Flush while full with a concurrent fetch.
    cycle(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0113, 32'h504, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0193, 32'h508, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Drive the counter into saturation with repeated load-use pairs.
    for (int i = 0; i < 2**CNT_W + 1; i++) begin
      cycle(1'b1, 32'h0001_2283, 32'h600 + 32'(8 * i), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'h0012_8333, 32'h604 + 32'(8 * i), 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    check("stall_cnt_saturated", 64'(stall_cnt), 64'(2**CNT_W - 1));

    // Reset in the middle of a stream.
    cycle(1'b1, 32'h0050_0093, 32'h700, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0113, 32'h704, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("midreset_stall_cnt", 64'(stall_cnt), 64'(0));
    check("midreset_dec_instr", 64'(dec_instr), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, v, rdy, fl;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = r ? 1'b0 : ($urandom_range(0, 3) != 0);
      fl  = r ? 1'b0 : ($urandom_range(0, 19) == 0);
      cycle(v, rand_instr(), pc_ctr, rdy, fl, r);
      pc_ctr = pc_ctr + 32'd4;
    end

    idle(6);
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
